// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian request controller.
package ped_pkg;

  localparam int LIGHTSEQ_W = 5;

  localparam int WALK_BIT  = 4;
  localparam int DWALK_BIT = 3;
  localparam int RED_BIT   = 2;
  localparam int AMBER_BIT = 1;
  localparam int GREEN_BIT = 0;

  localparam logic [LIGHTSEQ_W-1:0] LS_CAR_GREEN = 5'b01001;
  localparam logic [LIGHTSEQ_W-1:0] LS_CAR_AMBER = 5'b01010;
  localparam logic [LIGHTSEQ_W-1:0] LS_PED_WALK  = 5'b10100;
  localparam logic [LIGHTSEQ_W-1:0] LS_RED_AMBER = 5'b01110;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SERVING
  } state_t;

  function automatic logic is_legal(input logic [LIGHTSEQ_W-1:0] code);
    return (code == LS_CAR_GREEN) || (code == LS_CAR_AMBER) ||
           (code == LS_PED_WALK)  || (code == LS_RED_AMBER);
  endfunction

endpackage

// File: rtl/ped_request_ctrl_debounce.sv
// Button synchroniser, debounce counter and debounced rising-edge detect.
module ped_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic deb_level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      deb_q <= deb_level;
      if (sync2 == deb_level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb_level <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = deb_level & ~deb_q;

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian request FSM, beeper, served counter and lightseq checker.
module ped_request_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BEEP_DIV        = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  button,
  input  logic [LIGHTSEQ_W-1:0] lightseq,
  output logic                  start,
  output logic                  wait_lamp,
  output logic                  beep,
  output logic [7:0]            served_count,
  output logic                  seq_err
);

  localparam int BW = $clog2(BEEP_DIV) + 1;
  localparam logic [BW-1:0] DIV_LAST = BW'(BEEP_DIV - 1);

  state_t                state;
  state_t                next_state;
  logic                  press;
  logic                  deb_level;
  logic                  again;
  logic                  walk;
  logic                  serve;
  logic [BW-1:0]         div;
  logic [LIGHTSEQ_W-1:0] ls_q;

  ped_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .reset    (reset),
    .button   (button),
    .deb_level(deb_level),
    .press    (press)
  );

  assign walk  = lightseq[WALK_BIT];
  assign serve = (state == PENDING) && walk;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (press) next_state = PENDING;
      PENDING: if (walk) next_state = SERVING;
      SERVING: begin
        if (!walk) next_state = (again || press) ? PENDING : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start     = (state == PENDING);
    wait_lamp = (state == PENDING);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      again <= 1'b0;
    end else if (state != SERVING || !walk) begin
      again <= 1'b0;
    end else if (press) begin
      again <= 1'b1;
    end
  end

  // Divider and tone are held clear unless staying in SERVING.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div  <= '0;
      beep <= 1'b0;
    end else if (state != SERVING || next_state != SERVING) begin
      div  <= '0;
      beep <= 1'b0;
    end else if (div == DIV_LAST) begin
      div  <= '0;
      beep <= ~beep;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      served_count <= '0;
    end else if (serve && served_count != 8'hff) begin
      served_count <= served_count + 8'd1;
    end
  end

  // Input register resets to a legal code so reset alone never flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ls_q    <= LS_CAR_GREEN;
      seq_err <= 1'b0;
    end else begin
      ls_q    <= lightseq;
      seq_err <= seq_err | ~is_legal(ls_q);
    end
  end

endmodule
